// File: rtl/mtimer_deadline_sched.sv
// Deadline scheduler for the mtimer: keeps mtimecmp on the earliest armed slot,
// retires that slot as an event on timer_irq_i, and drives the timer over APB.
//
// state  | meaning
// INIT   | single CTRL write (enable + prescaler) after reset
// IDLE   | evaluate fire / reprogram decisions
// WR     | three-write mtimecmp update (HI=ones, LO, HI)
// SETTLE | one cycle for the timer irq to reflect the new compare
module mtimer_deadline_sched #(
  parameter int unsigned NUM_SLOTS  = 4,
  parameter logic [31:0] TIMER_BASE = 32'h0000_0000,
  parameter logic [2:0]  PRESCALER  = 3'd0,
  localparam int unsigned SW        = $clog2(NUM_SLOTS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          arm_valid_i,
  output logic          arm_ready_o,
  input  logic [SW-1:0] arm_slot_i,
  input  logic [63:0]   arm_deadline_i,
  input  logic          cancel_i,
  input  logic [SW-1:0] cancel_slot_i,
  output logic          evt_valid_o,
  output logic [SW-1:0] evt_slot_o,
  input  logic          evt_ready_i,
  input  logic          timer_irq_i,
  output logic          psel_o,
  output logic          penable_o,
  output logic          pwrite_o,
  output logic [31:0]   paddr_o,
  output logic [31:0]   pwdata_o,
  input  logic          pready_i,
  input  logic          pslverr_i,
  output logic          busy_o,
  output logic          err_o
);

  localparam logic [31:0] ADDR_CMP_LO = TIMER_BASE + 32'h08;
  localparam logic [31:0] ADDR_CMP_HI = TIMER_BASE + 32'h0C;
  localparam logic [31:0] ADDR_CTRL   = TIMER_BASE + 32'h10;
  localparam logic [31:0] CTRL_INIT   = {21'h0, PRESCALER, 7'h0, 1'b1};

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_SETTLE} state_e;

  state_e                state_q, state_d;
  logic                  psel_q, psel_d, penable_q, penable_d;
  logic [31:0]           paddr_q, paddr_d, pwdata_q, pwdata_d;
  logic [1:0]            wr_idx_q, wr_idx_d;
  logic                  err_q, err_d;
  logic                  evt_valid_q, evt_valid_d;
  logic [SW-1:0]         evt_slot_q, evt_slot_d;
  logic [63:0]           tgt_dl_q, tgt_dl_d;
  logic [SW-1:0]         tgt_slot_q, tgt_slot_d;
  logic                  tgt_valid_q, tgt_valid_d;
  logic [63:0]           prog_dl_q, prog_dl_d;
  logic [SW-1:0]         prog_slot_q, prog_slot_d;
  logic                  prog_valid_q, prog_valid_d;
  logic [NUM_SLOTS-1:0]  valid_q, valid_d;
  logic [63:0]           dl_q [NUM_SLOTS];
  logic [63:0]           dl_d [NUM_SLOTS];

  logic [63:0]           min_dl;
  logic [SW-1:0]         min_slot;
  logic                  min_found;
  logic                  fire, mismatch;

  // Strict less-than keeps the lowest index on equal deadlines.
  always_comb begin
    min_dl    = '1;
    min_slot  = '0;
    min_found = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (valid_q[i] && (!min_found || dl_q[i] < min_dl)) begin
        min_dl    = dl_q[i];
        min_slot  = SW'(i);
        min_found = 1'b1;
      end
    end
  end

  assign fire = timer_irq_i && prog_valid_q && valid_q[prog_slot_q] &&
                (dl_q[prog_slot_q] == prog_dl_q) && !evt_valid_q;
  assign mismatch = {min_dl, min_found} != {prog_dl_q, prog_valid_q};

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    wr_idx_d     = wr_idx_q;
    err_d        = err_q;
    evt_valid_d  = evt_valid_q;
    evt_slot_d   = evt_slot_q;
    tgt_dl_d     = tgt_dl_q;
    tgt_slot_d   = tgt_slot_q;
    tgt_valid_d  = tgt_valid_q;
    prog_dl_d    = prog_dl_q;
    prog_slot_d  = prog_slot_q;
    prog_valid_d = prog_valid_q;
    valid_d      = valid_q;
    dl_d         = dl_q;

    if (psel_q && penable_q && pready_i && pslverr_i) err_d = 1'b1;
    if (evt_valid_q && evt_ready_i) evt_valid_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (!psel_q) begin
          psel_d   = 1'b1;
          paddr_d  = ADDR_CTRL;
          pwdata_d = CTRL_INIT;
        end else if (!penable_q) begin
          penable_d = 1'b1;
        end else if (pready_i) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      S_IDLE: begin
        if (fire) begin
          evt_valid_d           = 1'b1;
          evt_slot_d            = prog_slot_q;
          valid_d[prog_slot_q]  = 1'b0;
          prog_valid_d          = 1'b0;
        end else if (mismatch) begin
          tgt_dl_d    = min_dl;
          tgt_slot_d  = min_slot;
          tgt_valid_d = min_found;
          wr_idx_d    = 2'd0;
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          paddr_d     = ADDR_CMP_HI;
          pwdata_d    = 32'hFFFF_FFFF;
          state_d     = S_WR;
        end
      end
      S_WR: begin
        if (!penable_q) begin
          penable_d = 1'b1;
        end else if (pready_i) begin
          penable_d = 1'b0;
          case (wr_idx_q)
            2'd0: begin
              paddr_d  = ADDR_CMP_LO;
              pwdata_d = tgt_dl_q[31:0];
              wr_idx_d = 2'd1;
            end
            2'd1: begin
              paddr_d  = ADDR_CMP_HI;
              pwdata_d = tgt_dl_q[63:32];
              wr_idx_d = 2'd2;
            end
            default: begin
              psel_d       = 1'b0;
              prog_dl_d    = tgt_dl_q;
              prog_slot_d  = tgt_slot_q;
              prog_valid_d = tgt_valid_q;
              state_d      = S_SETTLE;
            end
          endcase
        end
      end
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_INIT;
    endcase

    // Table writes apply in every state; cancel is applied last so it wins.
    if (arm_valid_i && arm_ready_o) begin
      valid_d[arm_slot_i] = 1'b1;
      dl_d[arm_slot_i]    = arm_deadline_i;
    end
    if (cancel_i) valid_d[cancel_slot_i] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      wr_idx_q     <= '0;
      err_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_slot_q   <= '0;
      tgt_dl_q     <= '1;
      tgt_slot_q   <= '0;
      tgt_valid_q  <= 1'b0;
      prog_dl_q    <= '1;
      prog_slot_q  <= '0;
      prog_valid_q <= 1'b0;
      valid_q      <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) dl_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      wr_idx_q     <= wr_idx_d;
      err_q        <= err_d;
      evt_valid_q  <= evt_valid_d;
      evt_slot_q   <= evt_slot_d;
      tgt_dl_q     <= tgt_dl_d;
      tgt_slot_q   <= tgt_slot_d;
      tgt_valid_q  <= tgt_valid_d;
      prog_dl_q    <= prog_dl_d;
      prog_slot_q  <= prog_slot_d;
      prog_valid_q <= prog_valid_d;
      valid_q      <= valid_d;
      for (int i = 0; i < NUM_SLOTS; i++) dl_q[i] <= dl_d[i];
    end
  end

  assign arm_ready_o = (state_q != S_INIT);
  assign busy_o      = (state_q != S_IDLE);
  assign evt_valid_o = evt_valid_q;
  assign evt_slot_o  = evt_slot_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = psel_q;
  assign paddr_o     = paddr_q;
  assign pwdata_o    = pwdata_q;
  assign err_o       = err_q;

endmodule
